// File: rtl/sum_accumulator.sv
// Purpose: accumulate adder sums into a saturating total and emit one result word per block.
// Latency: out_valid rises the cycle after the accept (or flush) that closes the block.
// Backpressure: in_ready drops while a result is held; HOLD persists until out_ready.
module sum_accumulator #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W:0]   in_sum,
  input  logic [7:0]        len,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic [8:0]        out_count,
  output logic              out_ovf
);

  localparam int PAD = ACC_W - DATA_W - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [8:0]       cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [8:0]       len_q, len_d;
  logic [ACC_W-1:0] out_acc_q, out_acc_d;
  logic [8:0]       out_count_q, out_count_d;
  logic             out_ovf_q, out_ovf_d;

  logic             accept;
  logic [ACC_W:0]   sum_wide;
  logic             close;

  // Handshake signals are a pure decode of the state register.
  always_comb begin
    in_ready  = (state_q != HOLD);
    out_valid = (state_q == HOLD);
    out_acc   = out_acc_q;
    out_count = out_count_q;
    out_ovf   = out_ovf_q;
  end

  // Next-state, accumulation and result capture.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    len_d       = len_q;
    out_acc_d   = out_acc_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;
    close       = 1'b0;
    accept      = in_valid & in_ready;
    // One extra bit catches the carry out of the accumulator.
    sum_wide    = {1'b0, acc_q} + {{(PAD + 1){1'b0}}, in_sum};

    case (state_q)
      IDLE: begin
        if (accept) begin
          // A length of 0 encodes a full 256-sample block.
          len_d = (len == 8'd0) ? 9'd256 : {1'b0, len};
          acc_d = {{PAD{1'b0}}, in_sum};
          cnt_d = 9'd1;
          ovf_d = 1'b0;
          close = (len_d == 9'd1) || flush;
          state_d = close ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          cnt_d = cnt_q + 9'd1;
          if (sum_wide[ACC_W]) begin
            acc_d = '1;
            ovf_d = 1'b1;
          end else begin
            acc_d = sum_wide[ACC_W-1:0];
          end
        end
        // A sample accepted alongside flush still belongs to this block.
        close = (accept && (cnt_d == len_q)) || flush;
        if (close) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Snapshot the block totals including any sample taken this cycle.
    if (close) begin
      out_acc_d   = acc_d;
      out_count_d = cnt_d;
      out_ovf_d   = ovf_d;
    end
  end

  // State and datapath registers; reset drops any partial block or pending result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      len_q       <= '0;
      out_acc_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      len_q       <= len_d;
      out_acc_q   <= out_acc_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

endmodule

// File: tb/tb_sum_accumulator.sv
// Bench for sum_accumulator: directed table, hand-written corner sequences, random traffic.
// A queue-based block model predicts handshakes and result words every cycle.
module tb_sum_accumulator;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [8:0]  in_sum;
  logic [7:0]  len;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_acc;
  logic [8:0]  out_count;
  logic        out_ovf;

  int checks = 0;
  int errors = 0;

  sum_accumulator #(.DATA_W(8), .ACC_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum),
    .len(len), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_acc(out_acc), .out_count(out_count), .out_ovf(out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: samples of the open block, and the pending result if any.
  bit  m_hold;
  int  m_q[$];
  int  m_len;
  int  e_acc;
  int  e_cnt;
  bit  e_ovf;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_hold = 1'b0;
    m_q.delete();
  endtask

  // Drive one cycle of inputs, check against the model, then advance the model.
  task automatic cycle(input bit v, input int s, input int l, input bit f, input bit r);
    longint t;
    @(negedge clk);
    in_valid  = v;
    in_sum    = 9'(s);
    len       = 8'(l);
    flush     = f;
    out_ready = r;
    #1;
    check("in_ready", in_ready, {31'd0, !m_hold});
    check("out_valid", out_valid, {31'd0, m_hold});
    if (m_hold) begin
      check("out_acc", out_acc, e_acc);
      check("out_count", out_count, e_cnt);
      check("out_ovf", out_ovf, {31'd0, e_ovf});
    end
    if (m_hold) begin
      if (r) m_hold = 1'b0;
    end else begin
      if (v) begin
        if (m_q.size() == 0) m_len = (l == 0) ? 256 : l;
        m_q.push_back(s);
      end
      if (m_q.size() > 0 && ((v && m_q.size() == m_len) || f)) begin
        t = 0;
        foreach (m_q[i]) t += m_q[i];
        e_ovf  = (t > 65535);
        e_acc  = e_ovf ? 65535 : int'(t);
        e_cnt  = m_q.size();
        m_hold = 1'b1;
        m_q.delete();
      end
    end
  endtask

  // Independent check of the result word just after the closing edge.
  task automatic expect_out(input string nm, input int acc, input int cnt, input bit ovf);
    @(posedge clk);
    #1;
    check({nm, "_valid"}, out_valid, 1);
    check({nm, "_rdy"}, in_ready, 0);
    check({nm, "_acc"}, out_acc, acc);
    check({nm, "_cnt"}, out_count, cnt);
    check({nm, "_ovf"}, out_ovf, {31'd0, ovf});
  endtask

  typedef struct {
    int len;
    int n;
    int s;
    bit fl;
    int acc;
    int cnt;
    bit ovf;
  } vec_t;

  vec_t tbl[7];

  initial begin
    tbl[0] = '{len: 0,   n: 256, s: 'h1FF, fl: 0, acc: 'hFFFF, cnt: 256, ovf: 1};
    tbl[1] = '{len: 10,  n: 3,   s: 5,     fl: 1, acc: 15,     cnt: 3,   ovf: 0};
    tbl[2] = '{len: 1,   n: 1,   s: 'h0AA, fl: 0, acc: 'h0AA,  cnt: 1,   ovf: 0};
    tbl[3] = '{len: 4,   n: 4,   s: 1,     fl: 0, acc: 4,      cnt: 4,   ovf: 0};
    tbl[4] = '{len: 2,   n: 2,   s: 'h100, fl: 0, acc: 'h200,  cnt: 2,   ovf: 0};
    tbl[5] = '{len: 128, n: 128, s: 'h1FF, fl: 0, acc: 'hFF80, cnt: 128, ovf: 0};
    tbl[6] = '{len: 129, n: 129, s: 'h1FF, fl: 0, acc: 'hFFFF, cnt: 129, ovf: 1};

    rst = 1'b1; in_valid = 0; in_sum = 0; len = 0; flush = 0; out_ready = 0;
    model_clear();
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_acc", out_acc, 0);
    check("rst_cnt", out_count, 0);
    check("rst_ovf", out_ovf, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_rdy", in_ready, 1);

    // Table-driven blocks with constant sample values.
    for (int i = 0; i < 7; i++) begin
      for (int k = 0; k < tbl[i].n; k++)
        cycle(1, tbl[i].s, tbl[i].len, tbl[i].fl && (k == tbl[i].n - 1), 1);
      expect_out($sformatf("tbl%0d", i), tbl[i].acc, tbl[i].cnt, tbl[i].ovf);
      cycle(0, 0, tbl[i].len, 0, 1);
    end

    // Basic block with differing sums and the one-cycle HOLD bubble.
    cycle(1, 'h010, 3, 0, 1);
    cycle(1, 'h020, 3, 0, 1);
    cycle(1, 'h1FE, 3, 0, 1);
    expect_out("basic", 'h22E, 3, 0);
    cycle(0, 0, 3, 0, 1);
    @(posedge clk); #1;
    check("basic_rdy_after", in_ready, 1);
    check("basic_valid_after", out_valid, 0);

    // Reset in the middle of a block discards it.
    cycle(1, 7, 4, 0, 1);
    cycle(1, 7, 4, 0, 1);
    @(negedge clk);
    in_valid = 0;
    rst = 1'b1;
    #1;
    check("mrst_valid", out_valid, 0);
    check("mrst_acc", out_acc, 0);
    check("mrst_cnt", out_count, 0);
    check("mrst_ovf", out_ovf, 0);
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) cycle(1, 1, 4, 0, 1);
    expect_out("mrst_next", 4, 4, 0);
    cycle(0, 0, 4, 0, 1);

    // Flush with no sample open never creates a block.
    for (int k = 0; k < 3; k++) cycle(0, 0, 3, 1, 1);
    @(posedge clk); #1;
    check("idle_flush_valid", out_valid, 0);

    // Output stall: result and in_ready held for five cycles.
    cycle(1, 'h0AA, 1, 0, 0);
    expect_out("bp", 'h0AA, 1, 0);
    for (int k = 0; k < 5; k++) begin
      cycle(0, 0, 1, 0, 0);
      check("bp_rdy", in_ready, 0);
      check("bp_acc", out_acc, 'h0AA);
    end
    cycle(0, 0, 1, 0, 1);
    @(posedge clk); #1;
    check("bp_idle_valid", out_valid, 0);
    check("bp_idle_rdy", in_ready, 1);

    // len changes after the first accept must not affect the open block.
    cycle(1, 3, 2, 0, 1);
    cycle(1, 3, 5, 0, 1);
    expect_out("lenrs_a", 6, 2, 0);
    cycle(0, 0, 5, 0, 1);
    for (int k = 0; k < 5; k++) cycle(1, 2, 5, 0, 1);
    expect_out("lenrs_b", 10, 5, 0);
    cycle(0, 0, 5, 0, 1);

    // Random traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      int l;
      int s;
      l = ($urandom % 8 == 0) ? 0 : int'($urandom_range(1, 12));
      s = ($urandom % 4 == 0) ? 'h1FF : int'($urandom % 512);
      cycle(($urandom % 4) != 0, s, l, ($urandom % 24) == 0, ($urandom % 3) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sum_accumulator.md
# sum_accumulator

Downstream stage for the 8-bit operand adder. Takes the 9-bit sum (8-bit result plus carry) over a valid/ready handshake, adds successive sums into a saturating accumulator, and closes a block after a programmable number of samples or on an early flush. Each closed block is presented as one result word (total, sample count, overflow flag) on a held valid/ready output port. This lets the design report multi-sample totals that the combinational adder cannot produce alone.

## Interface
- DATA_W, 8, width of adder operands; in_sum is DATA_W+1 bits (sum plus carry)
- ACC_W, 16, accumulator and result width; must be greater than DATA_W+1
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  upstream sum valid
- in_ready  out  1  block can accept a sum this cycle
- in_sum  in  DATA_W+1  adder result {carry, sum[DATA_W-1:0]}, unsigned
- len  in  8  samples per block, sampled on the first accept of a block; 0 means 256
- flush  in  1  close current block early (level, sampled each cycle)
- out_valid  out  1  result word available
- out_ready  in  1  downstream accepts result
- out_acc  out  ACC_W  block total, saturated
- out_count  out  9  number of samples in the block (1..256)
- out_ovf  out  1  block total saturated

## Operation
- Accept = in_valid & in_ready. Transfer = out_valid & out_ready.
- States:
  - IDLE: no samples in the current block.
  - ACCUM: at least one sample in the current block.
  - HOLD: result presented.
- in_ready = 1 in IDLE and ACCUM, 0 in HOLD. It is a combinational decode of state only.
- out_valid = 1 exactly in HOLD.
- IDLE:
  - On accept: latch len into len_q (0 → 256), acc = in_sum zero-extended, cnt = 1, ovf = 0.
  - If len_q == 1 or flush is high, go to HOLD; otherwise go to ACCUM.
  - flush with no accept is ignored; empty blocks are never produced.
- ACCUM:
  - On accept: sum = acc + in_sum, computed ACC_W+1 bits wide. If bit ACC_W is set, acc = all-ones and ovf = 1 (sticky); otherwise acc = sum. cnt = cnt + 1.
  - Go to HOLD when (accept & cnt+1 == len_q) or flush. An accept in the same cycle as flush is included in the result.
  - Otherwise stay in ACCUM.
- On entry to HOLD: out_acc, out_count and out_ovf load the final acc, cnt and ovf values, including any sample accepted in that cycle.
- HOLD:
  - Outputs remain stable until transfer.
  - On transfer: go to IDLE and clear acc, cnt and ovf. out_* keep their last values and are don't-care while out_valid = 0.
  - flush and in_valid are ignored in HOLD.
- Once ovf is set, acc stays at all-ones for the rest of the block.

## Timing
- Reset values (immediate, asynchronous): state IDLE, acc 0, cnt 0, ovf 0, len_q 0, out_acc 0, out_count 0, out_ovf 0, out_valid 0.
- in_ready is 1 once rst is deasserted. No accept occurs while rst is high.
- Reset asserted mid-block or in HOLD discards the partial block and any pending result. No result is emitted.
- Latency: out_valid rises on the cycle after the accept that completes the block (or after the flush cycle).
- Throughput: one block every len_q + 1 cycles with back-to-back input and out_ready held at 1. The extra cycle is the HOLD cycle, in which in_ready = 0.
- out_ready stalls: HOLD is held indefinitely with stable outputs, and in_ready stays 0, which back-pressures the adder side.
- A transfer in HOLD allows accepts again on the following cycle. There is no same-cycle transfer-and-accept.
- Changing len mid-block has no effect; it is sampled only on the first accept of a block.

## Test plan
- Basic block:
  - Stimulus: len=3, sums 0x010, 0x020, 0x1FE on consecutive cycles, out_ready=1.
  - Required: one cycle after the third accept, out_valid=1 with out_acc=0x022E, out_count=3, out_ovf=0. in_ready=0 in that cycle and 1 in the next.
- Saturation:
  - Stimulus: len=0 (256 samples), all sums 0x1FF.
  - Required: out_count=256, out_acc=0xFFFF, out_ovf=1. out_acc is first clamped at sample 129 (129×511 > 65535).
- Flush:
  - Stimulus: len=10, three sums of 5, with flush asserted on the third accept.
  - Required: out_acc=15, out_count=3.
  - Also: flush in IDLE with no in_valid produces no out_valid.
- Back-pressure:
  - Stimulus: len=1, sum 0x0AA, out_ready=0 for 5 cycles then 1.
  - Required: out_valid and outputs held stable throughout the stall, in_ready=0 for all 5 stall cycles, IDLE on the cycle after the transfer.
- Mid-operation reset:
  - Stimulus: len=4, assert rst after 2 accepts.
  - Required: all outputs go to reset values immediately. The next block starts fresh, so sums 1, 1, 1, 1 give out_acc=4, out_count=4.
- len resampling:
  - Stimulus: change len from 2 to 5 after the first accept of a block.
  - Required: the block closes after 2 samples. The next block uses 5.
